// File: rtl/f2d_queue.sv
`default_nettype none
// ============================================================================
//  Module      : f2d_queue
//  Description : Two-entry fetch-to-decode instruction queue. Buffers
//                {PC, Instr, BD, ExcCode} records between the instruction
//                fetch unit and the decode stage so that a decode stall does
//                not immediately stall fetch, and a flush discards everything
//                in flight.
//
//  Optional feature macro:
//    F2D_ADEL_CHECK_EN - when defined, each push is tagged ExcCode=4 (AdEL)
//                        if F_PC is misaligned or outside
//                        32'h00003000..32'h00006FFC; such entries store
//                        Instr=0. When undefined, ExcCode is always 0 and
//                        F_Instr is stored verbatim.
//
//  Ports:
//    clk        in   1   clock, rising edge
//    reset      in   1   asynchronous active-low reset
//    F_PC       in  32   PC of fetched instruction
//    F_Instr    in  32   instruction word at F_PC
//    F_BD       in   1   fetched instruction is in a delay slot
//    F_valid    in   1   fetch presents an entry
//    F_ready    out  1   queue can accept an entry (drives IFU PC_en)
//    D_ready    in   1   decode consumes the head entry
//    flush      in   1   redirect: discard all entries
//    D_valid    out  1   head entry valid
//    D_PC       out 32   head entry PC
//    D_Instr    out 32   head entry instruction
//    D_BD       out  1   head entry delay-slot flag
//    D_ExcCode  out  5   head entry exception code (0 none, 4 AdEL)
//    count      out  2   occupancy 0..2
//
//  Revision    : 1.0  initial release
// ============================================================================
module f2d_queue (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] F_PC,
   input  logic [31:0] F_Instr,
   input  logic        F_BD,
   input  logic        F_valid,
   output logic        F_ready,
   input  logic        D_ready,
   input  logic        flush,
   output logic        D_valid,
   output logic [31:0] D_PC,
   output logic [31:0] D_Instr,
   output logic        D_BD,
   output logic [4:0]  D_ExcCode,
   output logic [1:0]  count
);

   localparam logic [31:0] RESET_PC  = 32'h0000_3000;
   localparam logic [4:0]  EXC_NONE  = 5'd0;
   localparam logic [4:0]  EXC_ADEL  = 5'd4;
`ifdef F2D_ADEL_CHECK_EN
   localparam logic [31:0] TEXT_LO   = 32'h0000_3000;
   localparam logic [31:0] TEXT_HI   = 32'h0000_6FFC;
`endif

   // Storage
   logic [31:0] pc_mem    [2];
   logic [31:0] instr_mem [2];
   logic        bd_mem    [2];
   logic [4:0]  exc_mem   [2];

   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count_q;

   logic        push;
   logic        pop;
   logic        adel;
   logic [31:0] instr_in;
   logic [4:0]  exc_in;

   // Handshake flags derive from registered occupancy only, so there is no
   // combinational path from D_ready / F_valid to F_ready / D_valid.
   assign F_ready = (count_q != 2'd2);
   assign D_valid = (count_q != 2'd0);
   assign count   = count_q;

   assign push = F_valid && F_ready;
   assign pop  = D_valid && D_ready;

   // Head entry presented straight from storage; no empty-queue bypass.
   assign D_PC      = pc_mem[rd_ptr];
   assign D_Instr   = instr_mem[rd_ptr];
   assign D_BD      = bd_mem[rd_ptr];
   assign D_ExcCode = exc_mem[rd_ptr];

   // Address-error classification of the incoming fetch
`ifdef F2D_ADEL_CHECK_EN
   always_comb begin
      adel = 1'b0;
      if ((F_PC[1:0] != 2'b00) || (F_PC < TEXT_LO) || (F_PC > TEXT_HI)) begin
         adel = 1'b1;
      end
   end
`else
   assign adel = 1'b0;
`endif

   // A faulting fetch carries no meaningful instruction; a zero word keeps
   // decode from acting on whatever the bus returned.
   assign instr_in = adel ? 32'h0000_0000 : F_Instr;
   assign exc_in   = adel ? EXC_ADEL : EXC_NONE;

   // Pointers and occupancy; flush overrides any concurrent push/pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count_q <= 2'd0;
      end else if (flush) begin
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; written only on an accepted, non-flushed push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            pc_mem[i]    <= RESET_PC;
            instr_mem[i] <= 32'h0000_0000;
            bd_mem[i]    <= 1'b0;
            exc_mem[i]   <= EXC_NONE;
         end
      end else if (push && !flush) begin
         pc_mem[wr_ptr]    <= F_PC;
         instr_mem[wr_ptr] <= instr_in;
         bd_mem[wr_ptr]    <= F_BD;
         exc_mem[wr_ptr]   <= exc_in;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_f2d_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_f2d_queue
//  Description : Self-checking bench for f2d_queue. A vector table covers the
//                basic fill/stall/drain behaviour; hand-written sequences
//                cover streaming with pointer wrap, flush, AdEL tagging
//                (expectations follow F2D_ADEL_CHECK_EN) and asynchronous
//                reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_f2d_queue;

   logic        clk;
   logic        reset;
   logic [31:0] F_PC;
   logic [31:0] F_Instr;
   logic        F_BD;
   logic        F_valid;
   logic        F_ready;
   logic        D_ready;
   logic        flush;
   logic        D_valid;
   logic [31:0] D_PC;
   logic [31:0] D_Instr;
   logic        D_BD;
   logic [4:0]  D_ExcCode;
   logic [1:0]  count;

   int passed;
   int total;

   f2d_queue dut (
      .clk       (clk),
      .reset     (reset),
      .F_PC      (F_PC),
      .F_Instr   (F_Instr),
      .F_BD      (F_BD),
      .F_valid   (F_valid),
      .F_ready   (F_ready),
      .D_ready   (D_ready),
      .flush     (flush),
      .D_valid   (D_valid),
      .D_PC      (D_PC),
      .D_Instr   (D_Instr),
      .D_BD      (D_BD),
      .D_ExcCode (D_ExcCode),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fv;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        bd;
      logic        dr;
      logic        fl;
      logic        edv;
      logic [31:0] epc;
      logic [31:0] eins;
      logic        ebd;
      logic [1:0]  ecnt;
      logic        efr;
   } vec_t;

   vec_t vt [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic bd, input logic dr, input logic fl);
      F_valid = fv;
      F_PC    = pc;
      F_Instr = ins;
      F_BD    = bd;
      D_ready = dr;
      flush   = fl;
   endtask

   // Advance one rising edge and sample shortly after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_empty(input string name);
      check({name, "_cnt"}, {30'd0, count}, 32'd0);
      check({name, "_dv"},  {31'd0, D_valid}, 32'd0);
      check({name, "_fr"},  {31'd0, F_ready}, 32'd1);
   endtask

   logic [31:0] exp_exc_bad;
   logic [31:0] exp_ins_3002;
   logic [31:0] exp_ins_7000;

   initial begin
      passed = 0;
      total  = 0;

`ifdef F2D_ADEL_CHECK_EN
      exp_exc_bad  = 32'd4;
      exp_ins_3002 = 32'h0000_0000;
      exp_ins_7000 = 32'h0000_0000;
`else
      exp_exc_bad  = 32'd0;
      exp_ins_3002 = 32'hDEAD_BEEF;
      exp_ins_7000 = 32'h1234_5678;
`endif

      //            fv    pc            ins           bd    dr    fl    edv   epc           eins          ebd   cnt   fr
      vt[0] = '{1'b1, 32'h3000, 32'h3401_0001, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 32'h3401_0001, 1'b0, 2'd1, 1'b1};
      vt[1] = '{1'b1, 32'h3004, 32'h2002_0005, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3000, 32'h3401_0001, 1'b0, 2'd2, 1'b0};
      vt[2] = '{1'b1, 32'h3008, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 32'h3401_0001, 1'b0, 2'd2, 1'b0};
      vt[3] = '{1'b0, 32'h3008, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3004, 32'h2002_0005, 1'b1, 2'd1, 1'b1};
      vt[4] = '{1'b0, 32'h0,    32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,         1'b0, 2'd0, 1'b1};
      vt[5] = '{1'b0, 32'h0,    32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,         1'b0, 2'd0, 1'b1};
      vt[6] = '{1'b1, 32'h3010, 32'hAAAA_5555, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3010, 32'hAAAA_5555, 1'b1, 2'd1, 1'b1};
      vt[7] = '{1'b1, 32'h3014, 32'h0000_0011, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3014, 32'h0000_0011, 1'b0, 2'd1, 1'b1};

      // Reset state
      reset = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      #12;
      check_empty("rst");
      check("rst_pc",  D_PC, 32'h3000);
      check("rst_ins", D_Instr, 32'h0);
      check("rst_exc", {27'd0, D_ExcCode}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Table: fill, full back-pressure, drain, empty pop, push/pop mixes
      for (int i = 0; i < 8; i++) begin
         drive(vt[i].fv, vt[i].pc, vt[i].ins, vt[i].bd, vt[i].dr, vt[i].fl);
         tick();
         check($sformatf("v%0d_cnt", i), {30'd0, count}, {30'd0, vt[i].ecnt});
         check($sformatf("v%0d_dv", i),  {31'd0, D_valid}, {31'd0, vt[i].edv});
         check($sformatf("v%0d_fr", i),  {31'd0, F_ready}, {31'd0, vt[i].efr});
         if (vt[i].edv) begin
            check($sformatf("v%0d_pc", i),  D_PC, vt[i].epc);
            check($sformatf("v%0d_ins", i), D_Instr, vt[i].eins);
            check($sformatf("v%0d_bd", i),  {31'd0, D_BD}, {31'd0, vt[i].ebd});
            check($sformatf("v%0d_exc", i), {27'd0, D_ExcCode}, 32'd0);
         end
      end

      // Streaming at count=1: push and pop every cycle, pointers wrap
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 32'h3018 + 32'(4 * i), 32'(i), 1'b0, 1'b1, 1'b0);
         tick();
         check($sformatf("str%0d_cnt", i), {30'd0, count}, 32'd1);
         check($sformatf("str%0d_pc", i),  D_PC, 32'h3018 + 32'(4 * i));
         check($sformatf("str%0d_ins", i), D_Instr, 32'(i));
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
      check_empty("drain1");

      // Flush with full queue and a concurrent push/pop
      drive(1'b1, 32'h3100, 32'h1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h3104, 32'h2, 1'b0, 1'b0, 1'b0);
      tick();
      check("fl_full_cnt", {30'd0, count}, 32'd2);
      drive(1'b1, 32'h3108, 32'h3, 1'b0, 1'b1, 1'b1);
      tick();
      check_empty("flush");
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      check_empty("flush_lost");
      drive(1'b1, 32'h3200, 32'h5, 1'b0, 1'b0, 1'b0);
      tick();
      check("aft_fl_cnt", {30'd0, count}, 32'd1);
      check("aft_fl_pc",  D_PC, 32'h3200);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
      check_empty("drain2");

      // Address-error tagging
      drive(1'b1, 32'h3002, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      tick();
      check("a3002_exc", {27'd0, D_ExcCode}, exp_exc_bad);
      check("a3002_ins", D_Instr, exp_ins_3002);
      drive(1'b1, 32'h7000, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
      tick();
      check("a7000_pc",  D_PC, 32'h7000);
      check("a7000_exc", {27'd0, D_ExcCode}, exp_exc_bad);
      check("a7000_ins", D_Instr, exp_ins_7000);
      drive(1'b1, 32'h6FFC, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0);
      tick();
      check("a6ffc_pc",  D_PC, 32'h6FFC);
      check("a6ffc_exc", {27'd0, D_ExcCode}, 32'd0);
      check("a6ffc_ins", D_Instr, 32'h0BAD_F00D);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
      check_empty("drain3");

      // Asynchronous reset between edges with a full queue
      drive(1'b1, 32'h3300, 32'h7, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h3304, 32'h8, 1'b0, 1'b0, 1'b0);
      tick();
      check("ar_full_cnt", {30'd0, count}, 32'd2);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_empty("async_rst");
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 32'h3400, 32'h9, 1'b1, 1'b0, 1'b0);
      tick();
      check("ar_push_cnt", {30'd0, count}, 32'd1);
      check("ar_push_pc",  D_PC, 32'h3400);
      check("ar_push_bd",  {31'd0, D_BD}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/f2d_queue.md
F2D_QUEUE -- requirements
Module: f2d_queue

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; reset=0 clears all state immediately, independent of clk.
REQ-003 SHALL have port: F_PC  input  32  PC of fetched instruction from IFU.
REQ-004 SHALL have port: F_Instr  input  32  instruction word read at F_PC.
REQ-005 SHALL have port: F_BD  input  1  fetched instruction sits in a branch/jump delay slot.
REQ-006 SHALL have port: F_valid  input  1  IFU presents an entry this cycle.
REQ-007 SHALL have port: F_ready  output  1  queue accepts an entry this cycle; drives IFU PC_en.
REQ-008 SHALL have port: D_ready  input  1  decode stage consumes head entry (0 = decode stall).
REQ-009 SHALL have port: flush  input  1  exception/interrupt/eret redirect; discard all entries.
REQ-010 SHALL have port: D_valid  output  1  head entry valid.
REQ-011 SHALL have port: D_PC  output  32  head entry PC.
REQ-012 SHALL have port: D_Instr  output  32  head entry instruction.
REQ-013 SHALL have port: D_BD  output  1  head entry delay-slot flag.
REQ-014 SHALL have port: D_ExcCode  output  5  head entry exception code; 0 = none, 4 = AdEL.
REQ-015 SHALL have port: count  output  2  occupancy, 0..2.

Function
REQ-016 SHALL be a 2-entry FIFO of {PC, Instr, BD, ExcCode}, 1-bit read and write pointers that wrap 1->0.
REQ-017 SHALL push when F_valid && F_ready; pop when D_valid && D_ready.
REQ-018 SHALL drive F_ready = (count != 2), registered-state only; no combinational path from D_ready or F_valid.
REQ-019 SHALL drive D_valid = (count != 0); D_* outputs = head entry, combinational from storage.
REQ-020 SHALL have latency one cycle: entry pushed at edge N visible on D_* after edge N; no same-cycle bypass when empty.
REQ-021 SHALL on simultaneous push and pop with count=1 keep count=1, head advances to the newly pushed entry.
REQ-022 SHALL ignore pop when empty and never push when full (F_ready=0); count never exceeds 2 or underflows.
REQ-023 SHALL treat flush as highest priority: at that edge count:=0, pointers:=0, concurrent push and pop discarded; D_valid=0 the following cycle.
REQ-024 SHALL keep entry contents and count unchanged while D_ready=0 and no push/flush occurs.
REQ-025 SHALL compute ExcCode on push (see Configuration); entries with ExcCode=4 store Instr=32'h00000000.

Reset
REQ-026 SHALL on reset=0 set count=0, pointers=0, D_valid=0, F_ready=1, all storage PC fields=32'h00003000, Instr=0, BD=0, ExcCode=0.
REQ-027 SHALL, when reset asserts mid-operation, drop all entries immediately; first push after reset release is accepted normally.

Configuration
REQ-028 SHALL honour macro F2D_ADEL_CHECK_EN: defined -> push tags ExcCode=4 when F_PC[1:0]!=0 or F_PC outside 32'h00003000..32'h00006FFC inclusive, else 0.
REQ-029 SHALL, with F2D_ADEL_CHECK_EN undefined, store ExcCode=0 and F_Instr verbatim for every push.

Verification
REQ-030 SHALL cover: reset, push PC=0x3000 Instr=0x34010001 -> next cycle D_valid=1, D_PC=0x3000, count=1.
REQ-031 SHALL cover: D_ready=0, push 0x3000,0x3004 -> count=2, F_ready=0; third F_valid at 0x3008 not accepted; D_ready=1 -> D_PC 0x3000, then 0x3004.
REQ-032 SHALL cover: count=1, push and pop same cycle for 20 cycles, PC +4 each -> count stays 1, D_PC sequence continuous, pointer wrap exercised.
REQ-033 SHALL cover: count=2, flush=1 with F_valid=1 -> next cycle count=0, D_valid=0, F_ready=1; pushed entry lost.
REQ-034 SHALL cover (macro defined): push F_PC=0x3002 and 0x7000 -> D_ExcCode=4, D_Instr=0; push 0x6FFC -> D_ExcCode=0. Macro undefined: same stimulus -> D_ExcCode=0, Instr unchanged.
REQ-035 SHALL cover: reset=0 asserted between clock edges with count=2 -> D_valid=0 and count=0 before next rising edge.
